// File: rtl/rib_wait_slave.sv
// -----------------------------------------------------------------------------
// rib_wait_slave
//
// Slave-side responder for the RIB slave 7 port (req/busy handshake). It holds
// a word-addressed 32-bit memory and stretches every access by WAIT_CYCLES
// wait states. This gives slow peripherals (flash, external RAM, accelerators)
// a ready-made timing template and gives the interconnect a test target.
//
// Parameters
//   WAIT_CYCLES : wait states after the request cycle (0..15)
//   DEPTH       : number of 32-bit words (power of two)
//   AW          : word-index width, log2(DEPTH)
//
// Ports
//   clk     : system clock
//   rst     : asynchronous reset, active low
//   req_i   : access request from the interconnect (s7_req)
//   we_i    : 1 = write, 0 = read
//   addr_i  : byte address; word index = addr_i[AW+1:2], other bits ignored
//   data_i  : write data
//   data_o  : registered read data, valid in the DONE cycle and held after it
//   busy_o  : transaction in progress; feeds the interconnect hold logic
//
// Transaction timing: request in cycle T, busy_o high for T..T+WAIT_CYCLES,
// DONE (busy_o low) in cycle T+WAIT_CYCLES+1, then back to IDLE.
// -----------------------------------------------------------------------------
module rib_wait_slave #(
  parameter int unsigned WAIT_CYCLES = 3,
  parameter int unsigned DEPTH       = 1024,
  parameter int unsigned AW          = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        busy_o
);

  localparam logic [3:0] LP_WAIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  // Control state
  state_t        r_state;
  state_t        w_state_nxt;
  logic [3:0]    r_cnt;
  logic [3:0]    w_cnt_nxt;

  // Request captured in the IDLE request cycle, used during WAIT
  logic          r_we;
  logic [AW-1:0] r_idx;
  logic [31:0]   r_wdata;

  // Storage and read data
  logic [31:0]   r_mem [DEPTH];
  logic [31:0]   r_data_o;

  // Combinational decode
  logic          w_latch;
  logic          w_access;
  logic          w_busy;
  logic          w_acc_we;
  logic [AW-1:0] w_acc_idx;
  logic [31:0]   w_acc_wdata;
  logic          w_mem_wr;
  logic          w_mem_rd;

  // Slave-select bits, aliasing bits and the byte offset play no part here.
  logic          w_unused_addr;
  assign w_unused_addr = ^{addr_i[31:AW+2], addr_i[1:0]};

  // With zero wait states the access happens at the request edge itself, so
  // the access operands come straight from the inputs while in IDLE and from
  // the captured copies otherwise.
  assign w_acc_we    = (r_state == IDLE) ? we_i              : r_we;
  assign w_acc_idx   = (r_state == IDLE) ? addr_i[AW+1:2]    : r_idx;
  assign w_acc_wdata = (r_state == IDLE) ? data_i            : r_wdata;

  // Gating with rst keeps an edge seen while reset is held from committing a
  // write, and forces busy_o low for the whole reset interval.
  assign w_mem_wr = w_access &  w_acc_we & rst;
  assign w_mem_rd = w_access & ~w_acc_we & rst;
  assign busy_o   = w_busy & rst;
  assign data_o   = r_data_o;

  // ---------------------------------------------------------------------------
  // Next-state and output decode
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_latch     = 1'b0;
    w_access    = 1'b0;
    w_busy      = 1'b0;

    unique case (r_state)
      IDLE: begin
        // Hold asserts in the same cycle as the request.
        w_busy = req_i;
        if (req_i) begin
          w_latch   = 1'b1;
          w_cnt_nxt = LP_WAIT;
          if (LP_WAIT == 4'd0) begin
            w_access    = 1'b1;
            w_state_nxt = DONE;
          end else begin
            w_state_nxt = WAIT;
          end
        end
      end

      WAIT: begin
        // req_i is deliberately ignored: a dropped request still completes.
        w_busy    = 1'b1;
        w_cnt_nxt = r_cnt - 4'd1;
        if (r_cnt <= 4'd1) begin
          w_access    = 1'b1;
          w_state_nxt = DONE;
        end
      end

      DONE: begin
        // A req_i seen here is the held, completing request; never a new one.
        w_state_nxt = IDLE;
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Request capture (data only, no reset needed)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (w_latch) begin
      r_we    <= we_i;
      r_idx   <= addr_i[AW+1:2];
      r_wdata <= data_i;
    end
  end

  // ---------------------------------------------------------------------------
  // Memory array (contents survive reset)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (w_mem_wr) begin
      r_mem[w_acc_idx] <= w_acc_wdata;
    end
  end

  // ---------------------------------------------------------------------------
  // Read data register: changes only on read completion or reset
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_data_o <= 32'd0;
    end else if (w_mem_rd) begin
      r_data_o <= r_mem[w_acc_idx];
    end
  end

endmodule

// File: tb/tb_rib_wait_slave.sv
// -----------------------------------------------------------------------------
// tb_rib_wait_slave
//
// Two instances: u_dut0 with WAIT_CYCLES=3 and u_dut1 with WAIT_CYCLES=0.
// Each driven transaction pushes its expected DONE cycle and data_o value into
// a per-instance queue; a monitor pops and compares when busy_o falls.
// -----------------------------------------------------------------------------
module tb_rib_wait_slave;

  typedef struct {
    int          cyc;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst  [2];
  logic        req  [2];
  logic        we   [2];
  logic [31:0] addr [2];
  logic [31:0] wdata[2];
  logic [31:0] rdata[2];
  logic        busy [2];

  logic [31:0] lastrd[2];
  logic        prevb [2];
  exp_t        q0[$];
  exp_t        q1[$];
  int          cyc   = 0;
  int          n_cmp = 0;
  int          n_err = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  rib_wait_slave #(.WAIT_CYCLES(3), .DEPTH(1024), .AW(10)) u_dut0 (
    .clk(clk), .rst(rst[0]), .req_i(req[0]), .we_i(we[0]), .addr_i(addr[0]),
    .data_i(wdata[0]), .data_o(rdata[0]), .busy_o(busy[0])
  );

  rib_wait_slave #(.WAIT_CYCLES(0), .DEPTH(1024), .AW(10)) u_dut1 (
    .clk(clk), .rst(rst[1]), .req_i(req[1]), .we_i(we[1]), .addr_i(addr[1]),
    .data_i(wdata[1]), .data_o(rdata[1]), .busy_o(busy[1])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic push_exp(input int s, input int c, input logic [31:0] d);
    exp_t e;
    e.cyc  = c;
    e.data = d;
    if (s == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  // Called just after a rising edge; returns just after the edge following DONE.
  task automatic do_access(input int s, input logic w, input logic [31:0] a,
                           input logic [31:0] d, input logic [31:0] erd);
    int t;
    int wc;
    wc = (s == 0) ? 3 : 0;
    t  = cyc;
    req[s] = 1'b1; we[s] = w; addr[s] = a; wdata[s] = d;
    if (w) push_exp(s, t + wc + 1, lastrd[s]);
    else begin
      push_exp(s, t + wc + 1, erd);
      lastrd[s] = erd;
    end
    for (int k = 0; k <= wc + 1; k++) begin
      @(negedge clk);
      chk($sformatf("busy%0d_k%0d", s, k), {31'd0, busy[s]}, (k <= wc) ? 32'd1 : 32'd0);
    end
    @(posedge clk); #1;
    req[s] = 1'b0;
  endtask

  // DONE is the cycle where busy_o falls while out of reset.
  always @(negedge clk) begin
    for (int s = 0; s < 2; s++) begin
      if (!rst[s]) prevb[s] = 1'b0;
      else begin
        if (prevb[s] && !busy[s]) begin
          exp_t e;
          if ((s == 0 && q0.size() == 0) || (s == 1 && q1.size() == 0)) begin
            n_cmp++;
            n_err++;
            $display("FAIL done%0d: unexpected DONE at cycle %0d, none pending", s, cyc);
          end else begin
            if (s == 0) e = q0.pop_front();
            else        e = q1.pop_front();
            chk($sformatf("done_cyc%0d", s), cyc, e.cyc);
            chk($sformatf("data_o%0d", s), rdata[s], e.data);
          end
        end
        prevb[s] = busy[s];
      end
    end
  end

  initial begin
    int t;
    for (int s = 0; s < 2; s++) begin
      rst[s] = 1'b1; req[s] = 1'b0; we[s] = 1'b0; addr[s] = '0; wdata[s] = '0;
      lastrd[s] = '0; prevb[s] = 1'b0;
    end
    #2;
    rst[0] = 1'b0; rst[1] = 1'b0;
    repeat (2) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      chk($sformatf("rst_busy%0d", s), {31'd0, busy[s]}, 32'd0);
      chk($sformatf("rst_data%0d", s), rdata[s], 32'd0);
    end
    rst[0] = 1'b1; rst[1] = 1'b1;
    @(posedge clk); #1;

    // Back-to-back write/read, 3 wait states: 10 cycles for both.
    do_access(0, 1'b1, 32'h7000_0010, 32'hDEAD_BEEF, 32'h0);
    do_access(0, 1'b0, 32'h7000_0010, 32'h0, 32'hDEAD_BEEF);
    // Byte offset ignored.
    do_access(0, 1'b0, 32'h7000_0013, 32'h0, 32'hDEAD_BEEF);

    // Zero wait states.
    do_access(1, 1'b1, 32'h7000_0014, 32'h1234_5678, 32'h0);
    do_access(1, 1'b0, 32'h7000_0014, 32'h0, 32'h1234_5678);
    // Aliasing through ignored address bits.
    do_access(1, 1'b1, 32'h7000_0004, 32'hA5A5_A5A5, 32'h0);
    do_access(1, 1'b0, 32'h7000_1004, 32'h0, 32'hA5A5_A5A5);
    do_access(0, 1'b1, 32'h7000_0004, 32'hA5A5_A5A5, 32'h0);
    do_access(0, 1'b0, 32'h7000_1004, 32'h0, 32'hA5A5_A5A5);

    // Request dropped in the 2nd WAIT cycle: the write still completes.
    t = cyc;
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h7000_001C; wdata[0] = 32'h0000_CAFE;
    push_exp(0, t + 4, lastrd[0]);
    @(posedge clk); @(posedge clk); #1;
    req[0] = 1'b0;
    @(negedge clk); chk("drop_busy_w2", {31'd0, busy[0]}, 32'd1);
    @(negedge clk); chk("drop_busy_w3", {31'd0, busy[0]}, 32'd1);
    @(negedge clk); chk("drop_busy_done", {31'd0, busy[0]}, 32'd0);
    @(posedge clk); #1;
    do_access(0, 1'b0, 32'h7000_001C, 32'h0, 32'h0000_CAFE);

    // req held for 12 cycles: DONE at +4 and +9, third completes at +14.
    t = cyc;
    req[0] = 1'b1; we[0] = 1'b0; addr[0] = 32'h7000_001C;
    push_exp(0, t + 4,  32'h0000_CAFE);
    push_exp(0, t + 9,  32'h0000_CAFE);
    push_exp(0, t + 14, 32'h0000_CAFE);
    lastrd[0] = 32'h0000_CAFE;
    for (int k = 0; k <= 14; k++) begin
      @(negedge clk);
      chk($sformatf("hold_busy_k%0d", k), {31'd0, busy[0]},
          (k == 4 || k == 9 || k == 14) ? 32'd0 : 32'd1);
      if (k == 11) begin
        @(posedge clk); #1;
        req[0] = 1'b0;
      end
    end
    @(posedge clk); #1;

    // Reset during a write's WAIT phase discards the write.
    do_access(0, 1'b1, 32'h7000_000C, 32'h2222_2222, 32'h0);
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h7000_000C; wdata[0] = 32'h1111_1111;
    @(posedge clk); @(posedge clk); #1;
    rst[0] = 1'b0;
    #1;
    chk("rstwait_busy", {31'd0, busy[0]}, 32'd0);
    chk("rstwait_data", rdata[0], 32'd0);
    lastrd[0] = 32'h0;
    req[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst[0] = 1'b1;
    @(posedge clk); #1;
    do_access(0, 1'b0, 32'h7000_000C, 32'h0, 32'h2222_2222);

    repeat (3) @(posedge clk);
    #1;
    chk("q0_left", q0.size(), 32'd0);
    chk("q1_left", q1.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
